// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
//  Shared definitions for the butterfly sample-buffer peripheral:
//  register offsets relative to CTRL_BASE, STATUS bit positions, the start
//  bit and span-field width of the CTRL register, and the engine state type.
//  No ports; imported by fft_bfly_periph.
// ----------------------------------------------------------------------------
package fft_pkg;

   // Word offsets from CTRL_BASE
   localparam logic [13:0] OFS_DATA = 14'd0;
   localparam logic [13:0] OFS_CTRL = 14'd1;

   // STATUS register bit positions (count occupies bits 7:0)
   localparam int STAT_BUSY = 15;
   localparam int STAT_DONE = 14;
   localparam int STAT_OVF  = 13;

   // CTRL register layout: start strobe and stage-select field din[3:0]
   localparam int START_BIT = 15;
   localparam int SPAN_W    = 4;

   // Butterfly engine state
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } eng_state_e;

endpackage

// File: rtl/fft_bfly.sv
// ----------------------------------------------------------------------------
// fft_bfly
//  Combinational real-valued radix-2 butterfly. Sum and difference are
//  formed at DW+1 bits so no information is lost before the final
//  narrowing step.
//  Configuration macro FFT_SAT_EN:
//    defined   -> results saturate to the signed DW-bit range, clip flags it
//    undefined -> results are halved (arithmetic shift, floor), clip is 0
//  Ports:
//    x, y  in  DW  signed operands (two's complement)
//    sum   out DW  narrowed x+y
//    dif   out DW  narrowed x-y
//    clip  out 1   a saturation occurred on sum or dif this evaluation
// ----------------------------------------------------------------------------
module fft_bfly #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   output logic [DW-1:0] sum,
   output logic [DW-1:0] dif,
   output logic          clip
);

   logic [DW:0] sum_w;
   logic [DW:0] dif_w;

   // Sign-extend by one bit so the full-precision result always fits
   assign sum_w = {x[DW-1], x} + {y[DW-1], y};
   assign dif_w = {x[DW-1], x} - {y[DW-1], y};

`ifdef FFT_SAT_EN

   localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

   logic sum_clip;
   logic dif_clip;

   // The result leaves the DW-bit range exactly when the top two bits differ;
   // the extra top bit then gives the true sign and so the rail to clamp to.
   assign sum_clip = sum_w[DW] ^ sum_w[DW-1];
   assign dif_clip = dif_w[DW] ^ dif_w[DW-1];

   always_comb begin
      sum  = sum_w[DW-1:0];
      dif  = dif_w[DW-1:0];
      clip = sum_clip | dif_clip;
      if (sum_clip) begin
         sum = sum_w[DW] ? MIN_NEG : MAX_POS;
      end
      if (dif_clip) begin
         dif = dif_w[DW] ? MIN_NEG : MAX_POS;
      end
   end

`else

   logic unused_lsb;

   // Dropping the LSB of the DW+1 bit result is a floor divide by two,
   // which can never overflow, so clip is constant.
   assign sum        = sum_w[DW:1];
   assign dif        = dif_w[DW:1];
   assign clip       = 1'b0;
   assign unused_lsb = sum_w[0] ^ dif_w[0];

`endif

endmodule

// File: rtl/fft_bfly_periph.sv
// ----------------------------------------------------------------------------
// fft_bfly_periph
//  openMSP430 per_* bus peripheral: an N-deep signed sample shift buffer with
//  a sequential radix-2 butterfly engine that runs one stage (N/2 butterflies,
//  one per cycle) on request. The whole sample window is readable at any time.
//  Optional feature macro FFT_SAT_EN (see fft_bfly) selects saturating
//  arithmetic with a sticky ovf flag instead of the default halving.
//  Register map (word addresses):
//    SAMPLE_BASE+i  R   a[i], zero-extended
//    CTRL_BASE      W   DATA_IN: push a sample into a[0]   (reads 0)
//    CTRL_BASE+1    W   CTRL: din[15]=start, din[3:0]=stage s
//                   R   STATUS: {busy, done, ovf, 5'b0, count[7:0]}
//  Ports:
//    mclk      in   1   system clock
//    puc_rst   in   1   synchronous active-high reset
//    per_addr  in   14  word address
//    per_din   in   16  write data
//    per_en    in   1   bus cycle enable
//    per_we    in   2   byte write enables, 2'b00 = read
//    per_dout  out  16  read data, 0 unless a read hits this block
// ----------------------------------------------------------------------------
module fft_bfly_periph
   import fft_pkg::*;
#(
   parameter int          N           = 16,
   parameter int          DW          = 16,
   parameter logic [13:0] SAMPLE_BASE = 14'h88,
   parameter logic [13:0] CTRL_BASE   = 14'h98
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout
);

   localparam int               LOG2N     = $clog2(N);
   localparam logic [LOG2N:0]   COUNT_MAX = (LOG2N+1)'(N);
   localparam logic [LOG2N-1:0] K_LAST    = LOG2N'(N/2 - 1);

   // State registers
   logic [DW-1:0]     a_q [N];
   logic [DW-1:0]     a_d [N];
   logic [LOG2N:0]    count_q, count_d;
   logic [LOG2N-1:0]  k_q, k_d;
   logic [SPAN_W-1:0] s_q, s_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   eng_state_e        state_q, state_d;

   // Bus decode
   logic        wr_full;
   logic        rd_cycle;
   logic        data_wr;
   logic        ctrl_wr;
   logic        start_ok;
   logic        busy;
   logic [13:0] samp_ofs;
   logic        samp_hit;

   // Butterfly addressing and datapath
   logic [LOG2N:0]   k_ext, span_ext, low_mask, j_ext;
   logic [LOG2N-1:0] j_idx, p_idx;
   logic [DW-1:0]    bf_sum, bf_dif;
   logic             bf_clip;
   logic [15:0]      status;
   logic             unused_bits;

   assign busy     = (state_q == ST_RUN);
   assign wr_full  = per_en && (per_we == 2'b11);
   assign rd_cycle = per_en && (per_we == 2'b00);
   assign data_wr  = wr_full && (per_addr == CTRL_BASE + OFS_DATA);
   assign ctrl_wr  = wr_full && (per_addr == CTRL_BASE + OFS_CTRL);
   assign start_ok = ctrl_wr && per_din[START_BIT] && !busy &&
                     (per_din[SPAN_W-1:0] < SPAN_W'(LOG2N));

   // Addresses below SAMPLE_BASE wrap to large offsets and so miss the window
   assign samp_ofs = per_addr - SAMPLE_BASE;
   assign samp_hit = (samp_ofs < 14'(N));

   // Butterfly k pairs j (k with a 0 spliced in at bit s) with p = j + 2^s.
   // Bits of k below s stay put, bits at or above s move up one place.
   // Because k < N/2 the spliced index never reaches bit LOG2N.
   always_comb begin
      k_ext    = {1'b0, k_q};
      span_ext = (LOG2N+1)'(1) << s_q;
      low_mask = span_ext - (LOG2N+1)'(1);
      j_ext    = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
   end

   assign j_idx = j_ext[LOG2N-1:0];
   assign p_idx = j_idx | span_ext[LOG2N-1:0];

   fft_bfly #(
      .DW (DW)
   ) u_bfly (
      .x    (a_q[j_idx]),
      .y    (a_q[p_idx]),
      .sum  (bf_sum),
      .dif  (bf_dif),
      .clip (bf_clip)
   );

   // Next-state logic: sample pushes, stage start, and one butterfly commit
   // per cycle while running. Pushes and starts are refused while busy, so
   // the butterfly is the only writer of a_d during a stage.
   always_comb begin
      a_d     = a_q;
      count_d = count_q;
      k_d     = k_q;
      s_d     = s_q;
      done_d  = done_q;
      ovf_d   = ovf_q;
      state_d = state_q;

      unique case (state_q)
         ST_IDLE: begin
            if (data_wr) begin
               for (int i = N-1; i > 0; i--) begin
                  a_d[i] = a_q[i-1];
               end
               a_d[0]  = per_din[DW-1:0];
               count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
               done_d  = 1'b0;
            end
            if (start_ok) begin
               state_d = ST_RUN;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
               k_d     = '0;
               s_d     = per_din[SPAN_W-1:0];
            end
         end
         ST_RUN: begin
            // Both results derive from pre-edge a_q values
            a_d[j_idx] = bf_sum;
            a_d[p_idx] = bf_dif;
            ovf_d      = ovf_q | bf_clip;
            k_d        = k_q + 1'b1;
            if (k_q == K_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset clears everything including a stage in flight
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         for (int i = 0; i < N; i++) begin
            a_q[i] <= '0;
         end
         count_q <= '0;
         k_q     <= '0;
         s_q     <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         state_q <= ST_IDLE;
      end else begin
         a_q     <= a_d;
         count_q <= count_d;
         k_q     <= k_d;
         s_q     <= s_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
      end
   end

   // STATUS word; count is reported modulo 256 so N=256 reads back as 0.
   // ovf can only be set when saturation is built in.
   always_comb begin
      status            = '0;
      status[STAT_BUSY] = busy;
      status[STAT_DONE] = done_q;
      status[STAT_OVF]  = ovf_q;
      status[7:0]       = 8'(count_q);
   end

   // Combinational read mux, forced to 0 during reset and non-read cycles
   always_comb begin
      per_dout = '0;
      if (!puc_rst && rd_cycle) begin
         if (samp_hit) begin
            per_dout = 16'(a_q[samp_ofs[LOG2N-1:0]]);
         end else if (per_addr == CTRL_BASE + OFS_CTRL) begin
            per_dout = status;
         end
      end
   end

   assign unused_bits = ^{per_din[14:SPAN_W], j_ext[LOG2N], span_ext[LOG2N]};

endmodule

// File: tb/tb_fft_bfly_periph.sv
// ----------------------------------------------------------------------------
// tb_fft_bfly_periph
//  Self-checking bench for fft_bfly_periph (N=16, DW=16). A behavioural
//  model of the sample window and status flags supplies the expected values;
//  each expectation is queued when the read is issued and popped when the
//  read data is sampled. Honours FFT_SAT_EN for the expected arithmetic.
// ----------------------------------------------------------------------------
module tb_fft_bfly_periph;

   localparam int          N           = 16;
   localparam int          DW          = 16;
   localparam logic [13:0] SAMPLE_BASE = 14'h88;
   localparam logic [13:0] CTRL_BASE   = 14'h98;
   localparam logic [13:0] DATA_ADDR   = CTRL_BASE;
   localparam logic [13:0] STAT_ADDR   = CTRL_BASE + 14'd1;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q [$];

   // Behavioural model of the visible state
   logic [15:0] model [N];
   int          model_count;
   logic        model_done;
   logic        model_ovf;

   fft_bfly_periph #(
      .N           (N),
      .DW          (DW),
      .SAMPLE_BASE (SAMPLE_BASE),
      .CTRL_BASE   (CTRL_BASE)
   ) dut (
      .mclk     (mclk),
      .puc_rst  (puc_rst),
      .per_addr (per_addr),
      .per_din  (per_din),
      .per_en   (per_en),
      .per_we   (per_we),
      .per_dout (per_dout)
   );

   always #5 mclk = ~mclk;

   // ---------------- model ----------------
   function automatic void model_reset();
      for (int i = 0; i < N; i++) model[i] = '0;
      model_count = 0;
      model_done  = 1'b0;
      model_ovf   = 1'b0;
   endfunction

   function automatic void model_push(input logic [15:0] v);
      for (int i = N-1; i > 0; i--) model[i] = model[i-1];
      model[0] = v;
      if (model_count < N) model_count++;
      model_done = 1'b0;
   endfunction

   function automatic void model_stage(input int s);
      int span;
      int x, y, sm, df;
      span      = 1 << s;
      model_ovf = 1'b0;
      for (int j = 0; j < N; j++) begin
         if ((j & span) == 0) begin
            x  = int'($signed(model[j]));
            y  = int'($signed(model[j+span]));
            sm = x + y;
            df = x - y;
`ifdef FFT_SAT_EN
            if (sm > 32767)  begin sm = 32767;  model_ovf = 1'b1; end
            if (sm < -32768) begin sm = -32768; model_ovf = 1'b1; end
            if (df > 32767)  begin df = 32767;  model_ovf = 1'b1; end
            if (df < -32768) begin df = -32768; model_ovf = 1'b1; end
`else
            sm = sm >>> 1;
            df = df >>> 1;
`endif
            model[j]      = 16'(sm);
            model[j+span] = 16'(df);
         end
      end
      model_done = 1'b1;
   endfunction

   function automatic logic [15:0] model_status();
      return {1'b0, model_done, model_ovf, 5'b0, 8'(model_count)};
   endfunction

   // ---------------- bus drivers ----------------
   // Write: driven at negedge, committed at the following posedge.
   // dout_seen is per_dout sampled during the write cycle.
   task automatic bus_write(input logic [13:0] a, input logic [15:0] d,
                            input logic [1:0] we, output logic [15:0] dout_seen);
      @(negedge mclk);
      per_en   = 1'b1;
      per_we   = we;
      per_addr = a;
      per_din  = d;
      #1 dout_seen = per_dout;
      @(posedge mclk);
      #1;
      per_en = 1'b0;
      per_we = 2'b00;
      per_din = '0;
   endtask

   task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
      @(negedge mclk);
      per_en   = 1'b1;
      per_we   = 2'b00;
      per_addr = a;
      #1 d = per_dout;
      per_en = 1'b0;
   endtask

   task automatic push(input logic [15:0] v);
      logic [15:0] dummy;
      bus_write(DATA_ADDR, v, 2'b11, dummy);
      model_push(v);
   endtask

   task automatic start(input logic [3:0] s);
      logic [15:0] dummy;
      bus_write(STAT_ADDR, 16'h8000 | 16'(s), 2'b11, dummy);
   endtask

   // Polls STATUS until busy clears, counting the reads that saw busy
   task automatic run_until_idle(output int busy_reads, output bit timed_out);
      logic [15:0] st;
      busy_reads = 0;
      timed_out  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus_read(STAT_ADDR, st);
         if (!st[15]) begin
            timed_out = 1'b0;
            break;
         end
         busy_reads++;
      end
   endtask

   task automatic do_reset();
      @(negedge mclk);
      puc_rst = 1'b1;
      repeat (2) @(posedge mclk);
      #1 puc_rst = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] got, exp;
      do_reset();
      for (int i = 0; i < N; i += 5) begin
         exp_q.push_back(model[i]);
         bus_read(SAMPLE_BASE + 14'(i), got);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_a[%0d] got %h expected %h", i, got, exp);
         end
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL reset_status got %h expected %h", got, exp);
      end
   endtask

   task automatic test_push();
      logic [15:0] got, exp;
      for (int v = 1; v <= 16; v++) push(16'(v));
      exp_q.push_back(model[0]);
      bus_read(SAMPLE_BASE, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL push_a0 got %h expected %h", got, exp);
      end
      exp_q.push_back(model[N-1]);
      bus_read(SAMPLE_BASE + 14'(N-1), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL push_a15 got %h expected %h", got, exp);
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL push_count_full got %h expected %h", got, exp);
      end
      // 17th push drops the oldest sample; count saturates at N
      push(16'd17);
      exp_q.push_back(model[N-1]);
      bus_read(SAMPLE_BASE + 14'(N-1), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL push17_a15 got %h expected %h", got, exp);
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL push17_count got %h expected %h", got, exp);
      end
   endtask

   task automatic test_stage_basic();
      logic [15:0] got, exp;
      int          busy_reads;
      bit          timed_out;
      do_reset();
      push(16'd20);
      push(16'd100);
      start(4'd0);
      model_stage(0);
      run_until_idle(busy_reads, timed_out);
      checks++;
      if (timed_out || busy_reads != N/2) begin
         errors++;
         $display("[TB] FAIL stage_busy_cycles got %0d expected %0d (timeout=%0d)",
                  busy_reads, N/2, timed_out);
      end
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(model[i]);
         bus_read(SAMPLE_BASE + 14'(i), got);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL stage_a[%0d] got %h expected %h", i, got, exp);
         end
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL stage_done_status got %h expected %h", got, exp);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] got, exp;
      int          busy_reads;
      bit          timed_out;
      do_reset();
      push(16'h7000);
      push(16'h7000);
      start(4'd0);
      model_stage(0);
      run_until_idle(busy_reads, timed_out);
      checks++;
      if (timed_out) begin
         errors++;
         $display("[TB] FAIL ovf_stage_timeout got busy after %0d reads expected idle", busy_reads);
      end
      exp_q.push_back(model[0]);
      bus_read(SAMPLE_BASE, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL ovf_a0 got %h expected %h", got, exp);
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL ovf_status got %h expected %h", got, exp);
      end
   endtask

   task automatic test_ignored_controls();
      logic [15:0] got, exp, dummy;
      int          busy_reads;
      bit          timed_out;
      do_reset();
      for (int v = 0; v < N; v++) push(16'(v * 37 - 200));
      // Out-of-range stage select is refused
      start(4'd4);
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL bad_span_status got %h expected %h", got, exp);
      end
      for (int i = 0; i < N; i += 3) begin
         exp_q.push_back(model[i]);
         bus_read(SAMPLE_BASE + 14'(i), got);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL bad_span_a[%0d] got %h expected %h", i, got, exp);
         end
      end
      // Stage s=1 with a push and a restart attempted while busy
      start(4'd1);
      bus_write(DATA_ADDR, 16'd999, 2'b11, dummy);
      bus_write(STAT_ADDR, 16'h8000, 2'b11, dummy);
      model_stage(1);
      run_until_idle(busy_reads, timed_out);
      checks++;
      if (timed_out || busy_reads != N/2 - 2) begin
         errors++;
         $display("[TB] FAIL disturbed_busy_reads got %0d expected %0d (timeout=%0d)",
                  busy_reads, N/2 - 2, timed_out);
      end
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(model[i]);
         bus_read(SAMPLE_BASE + 14'(i), got);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL disturbed_a[%0d] got %h expected %h", i, got, exp);
         end
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL disturbed_status got %h expected %h", got, exp);
      end
   endtask

   task automatic test_reset_mid_stage();
      logic [15:0] got, exp;
      start(4'd0);
      repeat (2) @(posedge mclk);
      @(negedge mclk);
      puc_rst  = 1'b1;
      per_en   = 1'b1;
      per_we   = 2'b00;
      per_addr = STAT_ADDR;
      exp_q.push_back(16'h0000);
      #1 got = per_dout;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL dout_in_reset got %h expected %h", got, exp);
      end
      @(posedge mclk);
      #1;
      puc_rst = 1'b0;
      per_en  = 1'b0;
      model_reset();
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(model[i]);
         bus_read(SAMPLE_BASE + 14'(i), got);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("[TB] FAIL midreset_a[%0d] got %h expected %h", i, got, exp);
         end
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL midreset_status got %h expected %h", got, exp);
      end
   endtask

   task automatic test_bus_decode();
      logic [15:0] got, exp, seen;
      push(16'd5);
      bus_write(DATA_ADDR, 16'h1234, 2'b01, seen);
      bus_write(DATA_ADDR, 16'h5678, 2'b10, seen);
      exp_q.push_back(model[0]);
      bus_read(SAMPLE_BASE, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL byte_write_a0 got %h expected %h", got, exp);
      end
      exp_q.push_back(model_status());
      bus_read(STAT_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL byte_write_count got %h expected %h", got, exp);
      end
      // Full write to a sample address: no effect, per_dout 0 during the cycle
      exp_q.push_back(16'h0000);
      bus_write(SAMPLE_BASE, 16'hBEEF, 2'b11, seen);
      exp = exp_q.pop_front();
      checks++;
      if (seen !== exp) begin
         errors++;
         $display("[TB] FAIL dout_on_write got %h expected %h", seen, exp);
      end
      exp_q.push_back(model[0]);
      bus_read(SAMPLE_BASE, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL sample_write_ignored got %h expected %h", got, exp);
      end
      exp_q.push_back(16'h0000);
      bus_read(14'h0200, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL unmapped_read got %h expected %h", got, exp);
      end
      exp_q.push_back(16'h0000);
      bus_read(DATA_ADDR, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL data_in_read got %h expected %h", got, exp);
      end
   endtask

   initial begin
      puc_rst  = 1'b0;
      per_en   = 1'b0;
      per_we   = 2'b00;
      per_addr = '0;
      per_din  = '0;
      model_reset();
      test_reset();
      test_push();
      test_stage_basic();
      test_overflow();
      test_ignored_controls();
      test_reset_mid_stage();
      test_bus_decode();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
